y86_instr_writer: RTL and testbench

Y86_INSTR_WRITER -- requirements
Module: y86_instr_writer

---
 rtl/y86_instr_writer.sv | 198 +++++++++++++++++++
 tb/tb_y86_instr_writer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_instr_writer.sv
// Serialises one decoded Y86-64 instruction into byte writes at wr_ptr and advances the pointer.
// Optional macro WRITER_HALT_LOCK_EN: a successful halt write locks the writer until reset.
module y86_instr_writer #(
  parameter int unsigned MEM_DEPTH = 132
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ptr_load,
  input  logic [63:0] ptr_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [63:0] wr_ptr,
  output logic        done,
  output logic [3:0]  stat
);

  localparam logic [3:0] StatAok = 4'd0;
  localparam logic [3:0] StatHlt = 4'd1;
  localparam logic [3:0] StatAdr = 4'd2;
  localparam logic [3:0] StatIns = 4'd3;

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] wr_ptr_q, wr_ptr_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  stat_q, stat_d;
  logic [3:0]  ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;
  logic        locked;

  // Decode of the incoming instruction fields
  logic [3:0]  len_in;
  logic        ins_err, adr_err;
  logic [64:0] end_addr;

  always_comb begin
    len_in = 4'd1;
    unique case (icode)
      4'd0, 4'd1, 4'd9:          len_in = 4'd1;
      4'd2, 4'd6, 4'd10, 4'd11:  len_in = 4'd2;
      4'd7, 4'd8:                len_in = 4'd9;
      4'd3, 4'd4, 4'd5:          len_in = 4'd10;
      default:                   len_in = 4'd1;
    endcase
  end

  always_comb begin
    ins_err = 1'b0;
    if (icode > 4'd11) ins_err = 1'b1;
    if (ifun != 4'd0 && (icode == 4'd0 || icode == 4'd1 || icode == 4'd3 || icode == 4'd4 ||
                         icode == 4'd5 || icode == 4'd8 || icode == 4'd9 || icode == 4'd10 ||
                         icode == 4'd11)) ins_err = 1'b1;
    if ((icode == 4'd2 || icode == 4'd7) && ifun > 4'd6) ins_err = 1'b1;
    if (icode == 4'd6 && ifun > 4'd3) ins_err = 1'b1;
    if ((icode == 4'd10 || icode == 4'd11) && rB != 4'hf) ins_err = 1'b1;
    if (icode == 4'd3 && rA != 4'hf) ins_err = 1'b1;
  end

  assign end_addr = {1'b0, wr_ptr_q} + {61'd0, len_in};
  assign adr_err  = end_addr > 65'(MEM_DEPTH);

  // Next byte of the instruction being written
  logic [3:0] nk;
  logic [2:0] vidx;
  logic       has_reg;
  logic [7:0] next_byte;

  always_comb begin
    nk        = cnt_q + 4'd1;
    has_reg   = (len_q == 4'd2) || (len_q == 4'd10);
    vidx      = 3'(nk - (has_reg ? 4'd2 : 4'd1));
    next_byte = 8'(valc_q >> {vidx, 3'b000});
    if (has_reg && nk == 4'd1) next_byte = {ra_q, rb_q};
  end

  assign in_ready  = (state_q == StIdle) && !ptr_load && !locked;
  assign mem_we    = (state_q == StWrite);
  assign done      = (state_q == StDone);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wr_ptr    = wr_ptr_q;
  assign stat      = stat_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    stat_d   = stat_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    valc_d   = valc_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    halt_d   = halt_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (!locked && ptr_load) begin
          wr_ptr_d = ptr_in;
        end else if (in_valid && in_ready) begin
          ra_d   = rA;
          rb_d   = rB;
          valc_d = valC;
          len_d  = len_in;
          cnt_d  = 4'd0;
          halt_d = (icode == 4'd0);
          err_d  = ins_err || adr_err;
          if (ins_err) begin
            stat_d  = StatIns;
            state_d = StDone;
          end else if (adr_err) begin
            stat_d  = StatAdr;
            state_d = StDone;
          end else begin
            addr_d  = wr_ptr_q;
            wdata_d = {icode, ifun};
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (cnt_q == len_q - 4'd1) begin
          stat_d  = halt_q ? StatHlt : StatAok;
          state_d = StDone;
        end else begin
          cnt_d   = nk;
          addr_d  = wr_ptr_q + 64'(nk);
          wdata_d = next_byte;
        end
      end
      StDone: begin
        if (!err_q) wr_ptr_d = wr_ptr_q + 64'(len_q);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= 64'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 8'd0;
      stat_q   <= StatAok;
      ra_q     <= 4'd0;
      rb_q     <= 4'd0;
      valc_q   <= 64'd0;
      len_q    <= 4'd1;
      cnt_q    <= 4'd0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      stat_q   <= stat_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      valc_q   <= valc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
    end
  end

`ifdef WRITER_HALT_LOCK_EN
  logic locked_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q <= 1'b0;
    end else if (state_q == StDone && !err_q && stat_q == StatHlt) begin
      locked_q <= 1'b1;
    end
  end
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_y86_instr_writer.sv
// Bench for y86_instr_writer: vector table plus scoreboard of expected byte writes.
module tb_y86_instr_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ptr_load;
  logic [63:0] ptr_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [63:0] wr_ptr;
  logic        done;
  logic [3:0]  stat;

  y86_instr_writer #(.MEM_DEPTH(132)) dut (
    .clk       (clk),
    .reset     (reset),
    .ptr_load  (ptr_load),
    .ptr_in    (ptr_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .rA        (rA),
    .rB        (rB),
    .valC      (valC),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .wr_ptr    (wr_ptr),
    .done      (done),
    .stat      (stat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ld;
    logic [63:0] ptr;
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] vc;
    logic [3:0]  st;
    logic [3:0]  len;
  } vec_t;

  typedef struct packed {
    logic [63:0] a;
    logic [7:0]  d;
  } wr_t;

  int          n_checks = 0;
  int          n_fail = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic        touched [0:131];
  logic [63:0] exp_ptr;
  vec_t        vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected byte
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", mem_addr, mon_e.a);
        check("write_data", {56'd0, mem_wdata}, {56'd0, mon_e.d});
      end
      if (mem_addr < 64'd132) touched[int'(mem_addr)] = 1'b1;
    end
  end

  task automatic push_bytes(input logic [63:0] base, input logic [3:0] i_c, input logic [3:0] f_n,
                            input logic [3:0] r_a, input logic [3:0] r_b, input logic [63:0] v_c,
                            input logic [3:0] len);
    logic       hr;
    logic [63:0] sh;
    wr_t        e;
    hr = (len == 4'd2) || (len == 4'd10);
    for (int k = 0; k < int'(len); k++) begin
      e.a = base + 64'(k);
      if (k == 0) e.d = {i_c, f_n};
      else if (hr && k == 1) e.d = {r_a, r_b};
      else begin
        sh  = v_c >> (8 * (k - (hr ? 2 : 1)));
        e.d = sh[7:0];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic do_load(input logic [63:0] p);
    @(posedge clk); #1;
    ptr_load = 1'b1;
    ptr_in   = p;
    @(negedge clk);
    check("in_ready_during_load", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    ptr_load = 1'b0;
    exp_ptr  = p;
    @(negedge clk);
    check("wr_ptr_after_load", wr_ptr, exp_ptr);
  endtask

  task automatic send(input vec_t v);
    int n;
    if (v.ld) do_load(v.ptr);
    @(posedge clk); #1;
    in_valid = 1'b1;
    icode = v.ic; ifun = v.fn; rA = v.ra; rB = v.rb; valC = v.vc;
    if (v.st <= 4'd1) push_bytes(exp_ptr, v.ic, v.fn, v.ra, v.rb, v.vc, v.len);
    @(negedge clk);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check("done_latency", 64'(n), (v.st > 4'd1) ? 64'd1 : 64'(v.len) + 64'd1);
    check("stat", {60'd0, stat}, {60'd0, v.st});
    if (v.st <= 4'd1) exp_ptr = exp_ptr + 64'(v.len);
    @(negedge clk);
    check("done_pulse_width", {63'd0, done}, 64'd0);
    check("wr_ptr_after", wr_ptr, exp_ptr);
    check("stat_hold", {60'd0, stat}, {60'd0, v.st});
    check("bytes_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  int cnt;

  initial begin
    //           ld    ptr      ic     fn     ra     rb     valC                   st    len
    vecs[0]  = '{1'b1, 64'd0,   4'h3, 4'h0, 4'hf, 4'h2, 64'h0807060504030201, 4'd0, 4'd10};
    vecs[1]  = '{1'b0, 64'd0,   4'ha, 4'h0, 4'h3, 4'h0, 64'd0,                4'd3, 4'd2};
    vecs[2]  = '{1'b1, 64'd125, 4'h8, 4'h0, 4'h0, 4'h0, 64'd0,                4'd2, 4'd9};
    vecs[3]  = '{1'b1, 64'd123, 4'h8, 4'h0, 4'h0, 4'h0, 64'd0,                4'd0, 4'd9};
    vecs[4]  = '{1'b1, 64'd20,  4'h2, 4'h3, 4'h1, 4'h2, 64'd0,                4'd0, 4'd2};
    vecs[5]  = '{1'b0, 64'd0,   4'h6, 4'h4, 4'h1, 4'h2, 64'd0,                4'd3, 4'd2};
    vecs[6]  = '{1'b0, 64'd0,   4'h7, 4'h6, 4'h0, 4'h0, 64'h1122334455667788, 4'd0, 4'd9};
    vecs[7]  = '{1'b0, 64'd0,   4'h7, 4'h7, 4'h0, 4'h0, 64'd5,                4'd3, 4'd9};
    vecs[8]  = '{1'b0, 64'd0,   4'hc, 4'h0, 4'hf, 4'hf, 64'd0,                4'd3, 4'd1};
    vecs[9]  = '{1'b0, 64'd0,   4'h4, 4'h0, 4'h5, 4'h6, 64'hdeadbeefcafef00d, 4'd0, 4'd10};
    vecs[10] = '{1'b0, 64'd0,   4'h5, 4'h1, 4'h5, 4'h6, 64'd0,                4'd3, 4'd10};
    vecs[11] = '{1'b0, 64'd0,   4'h9, 4'h0, 4'h0, 4'h0, 64'd0,                4'd0, 4'd1};
    vecs[12] = '{1'b0, 64'd0,   4'hb, 4'h0, 4'h4, 4'hf, 64'd0,                4'd0, 4'd2};
    vecs[13] = '{1'b0, 64'd0,   4'h3, 4'h0, 4'h0, 4'h2, 64'd7,                4'd3, 4'd10};
    vecs[14] = '{1'b0, 64'd0,   4'hb, 4'h0, 4'h4, 4'h3, 64'd0,                4'd3, 4'd2};
    vecs[15] = '{1'b1, 64'd131, 4'h1, 4'h0, 4'h0, 4'h0, 64'd0,                4'd0, 4'd1};
    vecs[16] = '{1'b0, 64'd0,   4'h1, 4'h0, 4'h0, 4'h0, 64'd0,                4'd2, 4'd1};
    vecs[17] = '{1'b1, 64'd130, 4'h6, 4'h3, 4'h1, 4'h2, 64'd0,                4'd0, 4'd2};

    reset = 1'b1; ptr_load = 1'b0; ptr_in = 64'd0; in_valid = 1'b0;
    icode = 4'd0; ifun = 4'd0; rA = 4'd0; rB = 4'd0; valC = 64'd0;
    exp_ptr = 64'd0;
    for (int i = 0; i < 132; i++) touched[i] = 1'b0;
    #1;
    check("reset_wr_ptr", wr_ptr, 64'd0);
    check("reset_mem_we", {63'd0, mem_we}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_stat", {60'd0, stat}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 18; i++) send(vecs[i]);

    // ptr_load wins over in_valid in the same cycle
    @(posedge clk); #1;
    ptr_load = 1'b1; ptr_in = 64'd77;
    in_valid = 1'b1; icode = 4'h1; ifun = 4'h0;
    @(negedge clk);
    check("in_ready_load_and_valid", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    ptr_load = 1'b0; in_valid = 1'b0;
    exp_ptr = 64'd77;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("no_accept_with_load", 64'(cnt), 64'd0);
    check("wr_ptr_loaded", wr_ptr, 64'd77);

    // Reset in the middle of a 10-byte write
    do_load(64'd0);
    for (int i = 0; i < 132; i++) touched[i] = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; icode = 4'h3; ifun = 4'h0; rA = 4'hf; rB = 4'h2;
    valC = 64'h0807060504030201;
    push_bytes(64'd0, 4'h3, 4'h0, 4'hf, 4'h2, 64'h0807060504030201, 4'd10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    exp_q.delete();
    check("abort_mem_we", {63'd0, mem_we}, 64'd0);
    check("abort_wr_ptr", wr_ptr, 64'd0);
    check("abort_mem_addr", mem_addr, 64'd0);
    check("abort_mem_wdata", {56'd0, mem_wdata}, 64'd0);
    check("abort_stat", {60'd0, stat}, 64'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_abort", {63'd0, in_ready}, 64'd1);
    repeat (12) @(negedge clk);
    cnt = 0;
    for (int a = 3; a <= 9; a++) if (touched[a]) cnt++;
    check("abort_untouched_3_9", 64'(cnt), 64'd0);
    cnt = 0;
    for (int a = 0; a <= 2; a++) if (touched[a]) cnt++;
    check("abort_written_0_2", 64'(cnt), 64'd3);
    exp_ptr = 64'd0;

    // halt at pointer 0, then another instruction
    send('{1'b0, 64'd0, 4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 4'd1, 4'd1});
`ifdef WRITER_HALT_LOCK_EN
    @(posedge clk); #1;
    in_valid = 1'b1; icode = 4'h1; ifun = 4'h0;
    @(negedge clk);
    check("locked_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; ptr_load = 1'b1; ptr_in = 64'd50;
    @(posedge clk); #1;
    ptr_load = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("locked_no_done", 64'(cnt), 64'd0);
    check("locked_wr_ptr", wr_ptr, 64'd1);
    check("locked_stat", {60'd0, stat}, 64'd1);
`else
    send('{1'b0, 64'd0, 4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 4'd0, 4'd1});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
